retire_recovery_ctrl: RTL and testbench

- Sequences branch-mispredict recovery after the retire stage flags a mispredicted branch at the ROB head.
- Flushes the speculative back-end and rebuilds the speculative map table from the architectural map table over several cycles.
- Triggers the freelist rebuild, then hands the corrected PC to fetch with a valid/ready handshake.
- Sits between retire (trigger), the arch/spec map tables, the freelist, and fetch.

---
 rtl/retire_recovery_ctrl_pkg.sv | 18 +
 rtl/retire_recovery_ctrl_map_copy_sequencer.sv | 39 +++
 rtl/retire_recovery_ctrl.sv | 88 ++++++++
 tb/tb_retire_recovery_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_recovery_ctrl_pkg.sv
// rtl/retire_recovery_ctrl_pkg.sv - shared types for branch-mispredict recovery
package retire_recovery_ctrl_pkg;

    localparam int ARCH_REG_SZ     = 32;
    localparam int RECOVERY_COPY_W = 4;

    typedef logic [31:0] addr_t;
    typedef logic [4:0]  reg_idx_t;
    typedef logic [6:0]  phys_tag_t;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        COPY,
        REDIRECT
    } recovery_state_t;

endpackage

// File: rtl/retire_recovery_ctrl_map_copy_sequencer.sv
// rtl/retire_recovery_ctrl_map_copy_sequencer.sv - chunk counter and lane addresses for the map copy
module map_copy_sequencer
    import retire_recovery_ctrl_pkg::*;
#(
    parameter int ARCH_COUNT = ARCH_REG_SZ,
    parameter int COPY_W     = RECOVERY_COPY_W,
    localparam int CHUNKS    = ARCH_COUNT / COPY_W,
    localparam int CW        = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    active,
    output logic                    done,
    output reg_idx_t [COPY_W-1:0]   addrs
);

    logic [CW-1:0] chunk;

    assign done = active && (chunk == CW'(CHUNKS - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chunk <= '0;
        end else if (start) begin
            chunk <= '0;
        end else if (active) begin
            chunk <= done ? '0 : chunk + 1'b1;
        end
    end

    // Lanes cover consecutive registers of one chunk; zero outside COPY.
    always_comb begin
        for (int k = 0; k < COPY_W; k++) begin
            addrs[k] = active ? reg_idx_t'(int'(chunk) * COPY_W + k) : '0;
        end
    end

endmodule

// File: rtl/retire_recovery_ctrl.sv
// rtl/retire_recovery_ctrl.sv - flush, map rebuild and fetch redirect after a retire-time mispredict
module retire_recovery_ctrl
    import retire_recovery_ctrl_pkg::*;
#(
    parameter int ARCH_COUNT = ARCH_REG_SZ,
    parameter int COPY_W     = RECOVERY_COPY_W,
    parameter int CNT_W      = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mispredict_valid,
    input  addr_t                   mispredict_target,
    output reg_idx_t [COPY_W-1:0]   arch_rd_addrs,
    input  phys_tag_t [COPY_W-1:0]  arch_rd_tags,
    output logic [COPY_W-1:0]       map_wr_en,
    output reg_idx_t [COPY_W-1:0]   map_wr_addrs,
    output phys_tag_t [COPY_W-1:0]  map_wr_tags,
    output logic                    flush_out,
    output logic                    freelist_restore,
    output logic                    fetch_redirect_valid,
    output addr_t                   fetch_redirect_pc,
    input  logic                    fetch_redirect_ready,
    output logic                    retire_stall,
    output logic                    recovery_busy,
    output logic [CNT_W-1:0]        recovery_count
);

    recovery_state_t          state;
    addr_t                    target_q;
    logic                     copy_active;
    logic                     copy_done;
    reg_idx_t [COPY_W-1:0]    copy_addrs;

    assign copy_active = (state == COPY);

    map_copy_sequencer #(
        .ARCH_COUNT (ARCH_COUNT),
        .COPY_W     (COPY_W)
    ) u_seq (
        .clock  (clock),
        .reset  (reset),
        .start  (state == FLUSH),
        .active (copy_active),
        .done   (copy_done),
        .addrs  (copy_addrs)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            target_q       <= '0;
            recovery_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mispredict_valid) begin
                        target_q <= mispredict_target;
                        state    <= FLUSH;
                    end
                end
                FLUSH: state <= COPY;
                COPY: begin
                    if (copy_done) state <= REDIRECT;
                end
                REDIRECT: begin
                    if (fetch_redirect_ready) begin
                        state <= IDLE;
                        if (recovery_count != '1) recovery_count <= recovery_count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Everything except the tag pass-through is a decode of registered state.
    assign flush_out            = (state == FLUSH);
    assign freelist_restore     = (state == FLUSH);
    assign fetch_redirect_valid = (state == REDIRECT);
    assign fetch_redirect_pc    = (state == REDIRECT) ? target_q : '0;
    assign recovery_busy        = (state != IDLE);
    assign retire_stall         = (state != IDLE);
    assign map_wr_en            = {COPY_W{copy_active}};
    assign arch_rd_addrs        = copy_addrs;
    assign map_wr_addrs         = copy_addrs;
    assign map_wr_tags          = copy_active ? arch_rd_tags : '0;

endmodule

// File: tb/tb_retire_recovery_ctrl.sv
// tb/tb_retire_recovery_ctrl.sv - randomized self-checking bench for retire_recovery_ctrl
module tb_retire_recovery_ctrl;
    import retire_recovery_ctrl_pkg::*;

    localparam int ARCH_COUNT = 32;
    localparam int COPY_W     = 4;
    localparam int CHUNKS     = ARCH_COUNT / COPY_W;
    localparam int CNT_W      = 2;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic                    mispredict_valid = 1'b0;
    addr_t                   mispredict_target = '0;
    reg_idx_t [COPY_W-1:0]   arch_rd_addrs;
    phys_tag_t [COPY_W-1:0]  arch_rd_tags;
    logic [COPY_W-1:0]       map_wr_en;
    reg_idx_t [COPY_W-1:0]   map_wr_addrs;
    phys_tag_t [COPY_W-1:0]  map_wr_tags;
    logic                    flush_out;
    logic                    freelist_restore;
    logic                    fetch_redirect_valid;
    addr_t                   fetch_redirect_pc;
    logic                    fetch_redirect_ready = 1'b0;
    logic                    retire_stall;
    logic                    recovery_busy;
    logic [CNT_W-1:0]        recovery_count;

    retire_recovery_ctrl #(
        .ARCH_COUNT (ARCH_COUNT),
        .COPY_W     (COPY_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .mispredict_valid     (mispredict_valid),
        .mispredict_target    (mispredict_target),
        .arch_rd_addrs        (arch_rd_addrs),
        .arch_rd_tags         (arch_rd_tags),
        .map_wr_en            (map_wr_en),
        .map_wr_addrs         (map_wr_addrs),
        .map_wr_tags          (map_wr_tags),
        .flush_out            (flush_out),
        .freelist_restore     (freelist_restore),
        .fetch_redirect_valid (fetch_redirect_valid),
        .fetch_redirect_pc    (fetch_redirect_pc),
        .fetch_redirect_ready (fetch_redirect_ready),
        .retire_stall         (retire_stall),
        .recovery_busy        (recovery_busy),
        .recovery_count       (recovery_count)
    );

    always #5 clock = ~clock;

    phys_tag_t arch_map [ARCH_COUNT];
    phys_tag_t spec_map [ARCH_COUNT];
    int errors = 0;
    int checks = 0;
    int model_count = 0;

    // Arch map table model: combinational read.
    always_comb begin
        for (int k = 0; k < COPY_W; k++) arch_rd_tags[k] = arch_map[arch_rd_addrs[k]];
    end

    // Speculative map table model: written on the clock by the DUT.
    always @(posedge clock) begin
        for (int k = 0; k < COPY_W; k++)
            if (map_wr_en[k] === 1'b1) spec_map[map_wr_addrs[k]] = map_wr_tags[k];
    end

    function automatic bit all_quiet();
        return flush_out === 1'b0 && freelist_restore === 1'b0 && map_wr_en === '0 &&
               arch_rd_addrs === '0 && map_wr_addrs === '0 && map_wr_tags === '0 &&
               fetch_redirect_valid === 1'b0 && fetch_redirect_pc === '0 &&
               retire_stall === 1'b0 && recovery_busy === 1'b0;
    endfunction

    // One full recovery; entered and left #1 after a rising edge with the DUT idle.
    task automatic test_recovery_seq(input addr_t target, input int delay,
                                     input bit spurious, input bit trig_on_accept);
        bit ok;
        for (int i = 0; i < ARCH_COUNT; i++) spec_map[i] = 'x;
        checks++;
        if (recovery_busy !== 1'b0)
            begin errors++; $display("FAIL pre_idle busy=%b want 0", recovery_busy); end
        mispredict_valid = 1'b1;
        mispredict_target = target;
        fetch_redirect_ready = (delay == 0);
        checks++;
        if (flush_out !== 1'b0 || fetch_redirect_valid !== 1'b0)
            begin errors++; $display("FAIL trigger_cycle flush=%b valid=%b want 0 0", flush_out, fetch_redirect_valid); end
        @(posedge clock); #1;
        mispredict_valid = 1'b0;
        mispredict_target = $urandom;
        checks++;
        if ({flush_out, freelist_restore, recovery_busy, retire_stall, fetch_redirect_valid, |map_wr_en} !== 6'b111100)
            begin errors++; $display("FAIL flush_cycle got %b want 111100",
                {flush_out, freelist_restore, recovery_busy, retire_stall, fetch_redirect_valid, |map_wr_en}); end
        for (int j = 0; j < CHUNKS; j++) begin
            @(posedge clock); #1;
            ok = (map_wr_en === '1) && recovery_busy === 1'b1 && flush_out === 1'b0 &&
                 freelist_restore === 1'b0 && fetch_redirect_valid === 1'b0;
            for (int k = 0; k < COPY_W; k++) begin
                int e;
                e = j * COPY_W + k;
                if (arch_rd_addrs[k] !== reg_idx_t'(e) || map_wr_addrs[k] !== reg_idx_t'(e) ||
                    map_wr_tags[k] !== arch_map[e]) ok = 0;
            end
            checks++;
            if (!ok)
                begin errors++; $display("FAIL copy_chunk%0d en=%h addrs=%h waddrs=%h tags=%h want base %0d",
                    j, map_wr_en, arch_rd_addrs, map_wr_addrs, map_wr_tags, j * COPY_W); end
            mispredict_valid = spurious && (j == 2);
            mispredict_target = 32'hDEAD_0000;
        end
        mispredict_valid = 1'b0;
        @(posedge clock); #1;
        for (int i = 0; i <= delay; i++) begin
            checks++;
            if (fetch_redirect_valid !== 1'b1 || fetch_redirect_pc !== target ||
                recovery_busy !== 1'b1 || map_wr_en !== '0 || flush_out !== 1'b0)
                begin errors++; $display("FAIL redirect_cycle%0d valid=%b pc=%h busy=%b want 1 %h 1",
                    i, fetch_redirect_valid, fetch_redirect_pc, recovery_busy, target); end
            if (i == delay) begin
                fetch_redirect_ready = 1'b1;
                mispredict_valid = trig_on_accept;
                mispredict_target = $urandom;
            end
            @(posedge clock); #1;
        end
        fetch_redirect_ready = 1'b0;
        mispredict_valid = 1'b0;
        model_count = (model_count < CNT_MAX) ? model_count + 1 : CNT_MAX;
        checks++;
        if (all_quiet() !== 1'b1 || recovery_count !== CNT_W'(model_count))
            begin errors++; $display("FAIL post_accept quiet=%b count=%0d want 1 %0d",
                all_quiet(), recovery_count, model_count); end
        if (trig_on_accept) begin
            @(posedge clock); #1;
            checks++;
            if (all_quiet() !== 1'b1)
                begin errors++; $display("FAIL accept_trigger_ignored busy=%b flush=%b want 0 0", recovery_busy, flush_out); end
        end
        ok = 1;
        for (int i = 0; i < ARCH_COUNT; i++) if (spec_map[i] !== arch_map[i]) ok = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL map_rebuilt spec_map differs from arch_map"); end
    endtask

    task automatic randomize_map();
        for (int i = 0; i < ARCH_COUNT; i++) arch_map[i] = phys_tag_t'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (all_quiet() !== 1'b1 || recovery_count !== '0)
            begin errors++; $display("FAIL reset_outputs quiet=%b count=%0d want 1 0", all_quiet(), recovery_count); end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (all_quiet() !== 1'b1 || recovery_count !== '0)
            begin errors++; $display("FAIL reset_release quiet=%b count=%0d want 1 0", all_quiet(), recovery_count); end
        model_count = 0;
    endtask

    task automatic test_single();
        for (int i = 0; i < ARCH_COUNT; i++) arch_map[i] = phys_tag_t'(i + 40);
        test_recovery_seq(32'h0000_1040, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        randomize_map();
        test_recovery_seq($urandom, 5, 1'b0, 1'b0);
    endtask

    task automatic test_spurious();
        randomize_map();
        test_recovery_seq(32'h0000_2000 | ($urandom & 32'hFFC), 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_copy();
        randomize_map();
        mispredict_valid = 1'b1;
        mispredict_target = $urandom;
        @(posedge clock); #1;
        mispredict_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (map_wr_addrs[0] !== reg_idx_t'(3 * COPY_W))
            begin errors++; $display("FAIL midcopy_chunk addr=%0d want %0d", map_wr_addrs[0], 3 * COPY_W); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (all_quiet() !== 1'b1 || recovery_count !== '0)
            begin errors++; $display("FAIL midcopy_reset quiet=%b count=%0d want 1 0", all_quiet(), recovery_count); end
        @(negedge clock);
        reset = 1'b1;
        model_count = 0;
        @(posedge clock); #1;
        checks++;
        if (all_quiet() !== 1'b1 || recovery_count !== '0)
            begin errors++; $display("FAIL midcopy_release quiet=%b count=%0d want 1 0", all_quiet(), recovery_count); end
    endtask

    task automatic test_back_to_back();
        randomize_map();
        test_recovery_seq($urandom, $urandom_range(0, 3), 1'b0, 1'b0);
        randomize_map();
        test_recovery_seq($urandom, $urandom_range(0, 3), 1'b0, 1'b0);
        checks++;
        if (recovery_count !== CNT_W'(2))
            begin errors++; $display("FAIL back_to_back_count got %0d want 2", recovery_count); end
    endtask

    task automatic test_saturation();
        #2 reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_count = 0;
        @(posedge clock); #1;
        for (int n = 0; n < 5; n++) begin
            randomize_map();
            test_recovery_seq($urandom, $urandom_range(0, 2), 1'b0, n[0]);
        end
        checks++;
        if (recovery_count !== CNT_W'(CNT_MAX))
            begin errors++; $display("FAIL saturation_count got %0d want %0d", recovery_count, CNT_MAX); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_spurious();
        test_reset_mid_copy();
        test_back_to_back();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
